// File: rtl/window_reader.sv
// Circular capture buffer holding the latest DEPTH samples; on an accepted trigger
// the frozen window is replayed oldest-first over a valid/ready port.
module window_reader #(
    parameter int DEPTH = 20,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             trig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic {FILL, READ} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, remaining;
    logic [PW-1:0]    rd_start, rd_next;
    logic [CW-1:0]    cnt;
    logic             accept, xfer, wr_en;

    function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign xfer     = out_valid && out_ready;
    assign wr_en    = (state == FILL) && in_valid;
    assign busy     = (state == READ);
    assign out_last = out_valid && (remaining == '0);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        // A same-cycle write displaces the oldest entry, so the window starts one further on
        rd_start = in_valid ? incr(wr_ptr) : wr_ptr;
        rd_next  = incr(rd_ptr);
        case (state)
            FILL: begin
                if (trig && (cnt == FULL)) begin
                    accept  = 1'b1;
                    state_n = READ;
                end
            end
            READ: begin
                if (xfer && (remaining == '0)) state_n = FILL;
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_n;
    end

    // Sample storage is deliberately unreset; cnt keeps stale entries from being read
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= incr(wr_ptr);
                if (cnt != FULL) cnt <= cnt + 1'b1;
            end
            if (accept) begin
                rd_ptr    <= rd_start;
                out_data  <= (wr_en && (rd_start == wr_ptr)) ? in_data : mem[rd_start];
                out_valid <= 1'b1;
                remaining <= LAST_IDX;
            end else if (busy && xfer) begin
                if (remaining != '0) begin
                    rd_ptr    <= rd_next;
                    out_data  <= mem[rd_next];
                    remaining <= remaining - 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_reader.sv
// Randomized and directed bench for window_reader against a queue-based window model.
module tb_window_reader;

    localparam int DEPTH = 20;
    localparam int WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             trig;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;

    // hist: samples eligible for the next window; pend: words still to be delivered
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] pend[$];

    window_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .trig     (trig),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit full;
        full = (hist.size() == DEPTH);
        if (pend.size() > 0) begin
            if (out_ready) void'(pend.pop_front());
        end else begin
            if (in_valid) begin
                hist.push_back(in_data);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            if (trig && full) begin
                pend = hist;
                hist.delete();
            end
        end
    endtask

    task automatic compare_outputs();
        bit act;
        act = (pend.size() > 0);
        check("busy",      32'(busy),      32'(act));
        check("out_valid", 32'(out_valid), 32'(act));
        check("out_last",  32'(out_last),  32'(pend.size() == 1));
        if (act) check("out_data", 32'(out_data), 32'(pend[0]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        trig     = 1'b0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic fire();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            out_ready = toggle ? (i % 3 == 0) : 1'b1;
            step();
        end
        out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  32'(out_data),  32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        trig      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Exactly one window, replayed with ready held high
        for (int v = 1; v <= 20; v++) push(WIDTH'(v));
        fire();
        drain(1'b0);

        // Window taken across the write-pointer wrap
        for (int v = 1; v <= 25; v++) push(WIDTH'(v));
        fire();
        drain(1'b0);

        // Trigger one sample short is ignored, then accepted once full
        for (int v = 1; v <= 19; v++) push(WIDTH'(v));
        fire();
        fire();
        push(WIDTH'(20));
        fire();
        drain(1'b0);

        // Trigger coincident with a new sample
        for (int v = 1; v <= 20; v++) push(WIDTH'(v));
        in_valid = 1'b1;
        in_data  = WIDTH'(21);
        fire();
        in_valid = 1'b0;
        drain(1'b0);

        // Stalling consumer, inputs and trigger during replay
        for (int v = 1; v <= 20; v++) push(WIDTH'(v));
        fire();
        for (int i = 0; i < 3 * DEPTH + 4; i++) begin
            out_ready = (i % 3 == 0);
            in_valid  = (i >= 2 && i < 8);
            in_data   = WIDTH'(100 + i - 2);
            trig      = (i == 10);
            step();
        end
        in_valid  = 1'b0;
        trig      = 1'b0;
        out_ready = 1'b1;
        for (int v = 201; v <= 220; v++) push(WIDTH'(v));
        fire();
        drain(1'b1);

        // Reset while the 7th word is on the port
        for (int v = 301; v <= 320; v++) push(WIDTH'(v));
        fire();
        repeat (6) step();
        check("pre_rst_word", 32'(out_data), 32'd307);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        pend.delete();
        hist.delete();
        #1;
        rst = 1'b0;
        for (int v = 401; v <= 420; v++) push(WIDTH'(v));
        fire();
        drain(1'b0);

        // Random traffic, triggers and backpressure
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] r;
            r         = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = r[WIDTH-1:0];
            trig      = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
